// File: rtl/prio_grant_arbiter.sv
// Four-requester grant arbiter: fixed priority (highest index wins) with hold limit,
// forced-release masking and a one-cycle turnaround. Define PRIO_ARB_ROUND_ROBIN_EN for round-robin search.
module prio_grant_arbiter #(
   parameter int N_REQ    = 4,
   parameter int IDX_W    = 2,
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             timeout
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_RECOVER = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

`ifdef PRIO_ARB_ROUND_ROBIN_EN
   // Descending search starting just below the previous owner, wrapping 0 -> N_REQ-1.
   function automatic logic [IDX_W-1:0] pick_winner(input logic [N_REQ-1:0] eff,
                                                    input logic [IDX_W-1:0] last);
      logic [IDX_W-1:0] cand;
      logic [IDX_W-1:0] w;
      logic             found;
      w     = last;
      found = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = last - IDX_W'(k);
         if (!found && eff[cand]) begin
            w     = cand;
            found = 1'b1;
         end
      end
      return w;
   endfunction
`else
   // Priority encoder: highest set bit wins.
   function automatic logic [IDX_W-1:0] pick_winner(input logic [N_REQ-1:0] eff);
      logic [IDX_W-1:0] w;
      w = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (eff[i]) begin
            w = IDX_W'(i);
         end
      end
      return w;
   endfunction
`endif

   state_t           state_q,   state_d;
   logic [N_REQ-1:0] gnt_q,     gnt_d;
   logic             valid_q,   valid_d;
   logic             timeout_q, timeout_d;
   logic [7:0]       hold_q,    hold_d;
   logic [N_REQ-1:0] mask_q,    mask_d;
   // last_idx doubles as gnt_idx: it holds the owner's index through release.
   logic [IDX_W-1:0] last_q,    last_d;

   logic [N_REQ-1:0] eff_s;
   logic [N_REQ-1:0] mask_set_s;
   logic [IDX_W-1:0] win_s;

   // Next-state and registered-output computation.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      valid_d    = valid_q;
      timeout_d  = 1'b0;
      hold_d     = hold_q;
      last_d     = last_q;
      mask_set_s = '0;
      eff_s      = req & ~mask_q;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
      win_s      = pick_winner(eff_s, last_q);
`else
      win_s      = pick_winner(eff_s);
`endif
      case (state_q)
         S_IDLE: begin
            if (|eff_s) begin
               gnt_d   = N_REQ'(1'b1) << win_s;
               valid_d = 1'b1;
               hold_d  = 8'd0;
               last_d  = win_s;
               state_d = S_GRANT;
            end else begin
               gnt_d   = '0;
               valid_d = 1'b0;
            end
         end
         S_GRANT: begin
            if (!req[last_q]) begin
               gnt_d   = '0;
               valid_d = 1'b0;
               state_d = S_RECOVER;
            end else if (hold_q == HOLD_LAST) begin
               gnt_d              = '0;
               valid_d            = 1'b0;
               timeout_d          = 1'b1;
               mask_set_s[last_q] = 1'b1;
               state_d            = S_RECOVER;
            end else begin
               hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
            end
         end
         S_RECOVER: begin
            gnt_d   = '0;
            valid_d = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            gnt_d   = '0;
            valid_d = 1'b0;
            state_d = S_IDLE;
         end
      endcase
      // A requester's mask drops on any edge where it is not requesting.
      mask_d = (mask_q & req) | mask_set_s;
   end

   // State and output registers, asynchronously cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         gnt_q     <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         hold_q    <= 8'd0;
         mask_q    <= '0;
         last_q    <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         hold_q    <= hold_d;
         mask_q    <= mask_d;
         last_q    <= last_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = last_q;
   assign gnt_valid = valid_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_prio_grant_arbiter.sv
// Directed bench for prio_grant_arbiter with MAX_HOLD=4; round-robin sequence runs only when
// PRIO_ARB_ROUND_ROBIN_EN is defined.
module tb_prio_grant_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout;

   int vectors;
   int errors;

   prio_grant_arbiter #(.N_REQ(4), .IDX_W(2), .MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                      input logic ev, input logic et);
      logic [7:0] obs;
      logic [7:0] exp;
      obs = {gnt, gnt_idx, gnt_valid, timeout};
      exp = {eg, ei, ev, et};
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed {gnt,idx,valid,timeout}=%b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      logic [1:0] rr_exp [5];
      vectors = 0;
      errors  = 0;
      rst     = 1'b1;
      req     = 4'b0000;
      step();
      step();
      chk("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      chk("idle_no_req", 4'b0000, 2'd0, 1'b0, 1'b0);

      // Fixed priority then handover after turnaround
      req = 4'b0110;
      step();
      chk("fixed_win2", 4'b0100, 2'd2, 1'b1, 1'b0);
      req = 4'b0010;
      step();
      chk("release2", 4'b0000, 2'd2, 1'b0, 1'b0);
      step();
      chk("recover2", 4'b0000, 2'd2, 1'b0, 1'b0);
      step();
      chk("handover1", 4'b0010, 2'd1, 1'b1, 1'b0);
      req = 4'b0000;
      step();
      chk("release1", 4'b0000, 2'd1, 1'b0, 1'b0);
      step();
      step();

      // No preemption by a higher-priority arrival
      req = 4'b0001;
      step();
      chk("grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
      req = 4'b1001;
      step();
      chk("no_preempt", 4'b0001, 2'd0, 1'b1, 1'b0);
      req = 4'b1000;
      step();
      chk("release0", 4'b0000, 2'd0, 1'b0, 1'b0);
      step();
      step();
      chk("next_is_3", 4'b1000, 2'd3, 1'b1, 1'b0);
      req = 4'b0000;
      step();
      step();
      step();

      // Hold limit: idx3 owns for exactly 4 cycles, then timeout and mask
      req = 4'b1001;
      step();
      chk("to_grant3", 4'b1000, 2'd3, 1'b1, 1'b0);
      step();
      chk("to_hold1", 4'b1000, 2'd3, 1'b1, 1'b0);
      step();
      step();
      chk("to_hold3", 4'b1000, 2'd3, 1'b1, 1'b0);
      step();
      chk("to_pulse3", 4'b0000, 2'd3, 1'b0, 1'b1);
      step();
      chk("to_pulse_end", 4'b0000, 2'd3, 1'b0, 1'b0);
      step();
      chk("to_grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
      step();
      step();
      step();
      step();
      chk("to_pulse0", 4'b0000, 2'd0, 1'b0, 1'b1);
      step();
      step();
      chk("all_masked", 4'b0000, 2'd0, 1'b0, 1'b0);
      step();
      chk("all_masked2", 4'b0000, 2'd0, 1'b0, 1'b0);
      req = 4'b0001;
      step();
      chk("unmask3_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
      req = 4'b1001;
      step();
      chk("regrant3", 4'b1000, 2'd3, 1'b1, 1'b0);
      req = 4'b0000;
      step();
      step();
      step();

      // Release coinciding with hold limit: no timeout, no mask
      req = 4'b0100;
      step();
      chk("bnd_grant2", 4'b0100, 2'd2, 1'b1, 1'b0);
      step();
      step();
      step();
      req = 4'b0000;
      step();
      chk("bnd_release", 4'b0000, 2'd2, 1'b0, 1'b0);
      req = 4'b0100;
      step();
      step();
      chk("bnd_unmasked", 4'b0100, 2'd2, 1'b1, 1'b0);

      // Asynchronous reset while granted
      req = 4'b1100;
      step();
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
      req = 4'b0000;
      step();
      rst = 1'b0;
      step();
      chk("post_rst_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
      step();
      chk("post_rst_idle2", 4'b0000, 2'd0, 1'b0, 1'b0);

`ifdef PRIO_ARB_ROUND_ROBIN_EN
      rr_exp[0] = 2'd3;
      rr_exp[1] = 2'd2;
      rr_exp[2] = 2'd1;
      rr_exp[3] = 2'd0;
      rr_exp[4] = 2'd3;
      req = 4'b1111;
      step();
      chk("rr_first", 4'b0001 << rr_exp[0], rr_exp[0], 1'b1, 1'b0);
      for (int i = 1; i < 5; i++) begin
         req = 4'b1111 & ~(4'b0001 << rr_exp[i-1]);
         step();
         req = 4'b1111;
         step();
         step();
         chk("rr_next", 4'b0001 << rr_exp[i], rr_exp[i], 1'b1, 1'b0);
      end
`else
      rr_exp[0] = 2'd0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
